// File: rtl/output_channel_rr_buf.sv
// Wormhole output channel: arbitrates among IN_N inputs, locks the winner
// until its tail flit transfers, and buffers accepted flits in a small FIFO
// that decouples the downstream rdy/vld handshake from the input side.
module output_channel_rr_buf #(
  parameter int unsigned IN_N      = 5,
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned ARB_TYPE  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [IN_N-1:0]                req_i,
  input  logic [IN_N-1:0]                data_vld_i,
  input  logic [IN_N-1:0]                flit_id_is_tail_i,
  input  logic [IN_N*DATA_W-1:0]         ic_data_i,
  output logic [IN_N-1:0]                grant_o,
  output logic [IN_N-1:0]                ic_rdy_o,
  output logic                           oc_vld_o,
  input  logic                           oc_rdy_i,
  output logic [DATA_W-1:0]              oc_data_o,
  output logic [$clog2(OUT_DEPTH+1)-1:0] fifo_cnt_o,
  output logic                           busy_o
);

  localparam int unsigned IdxW = $clog2(IN_N);
  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned CntW = $clog2(OUT_DEPTH+1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IN_N-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [OUT_DEPTH];

  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   owner_idx;
  logic [IdxW-1:0]   next_ptr;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              push;
  logic              pop;
  logic              tail_xfer;

  // Arbiter: scan upward from rr pointer (round-robin) or from 0 (fixed).
  always_comb begin
    int unsigned j;
    logic        found;
    j       = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      j = (ARB_TYPE == 1) ? 32'(rr_ptr_q) + i : i;
      if (j >= IN_N) j = j - IN_N;
      if (!found && req_i[j]) begin
        found   = 1'b1;
        win_idx = IdxW'(j);
      end
    end
  end

  // Owner index and its flit data, selected by the one-hot owner register.
  always_comb begin
    owner_idx = '0;
    push_data = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      if (owner_q[i]) begin
        owner_idx = IdxW'(i);
        push_data = ic_data_i[i*DATA_W +: DATA_W];
      end
    end
    next_ptr = (owner_idx == IdxW'(IN_N-1)) ? '0 : owner_idx + IdxW'(1);
  end

  // Handshake outputs; ic_rdy_o already excludes the full case so push never overflows.
  always_comb begin
    full       = (cnt_q == CntW'(OUT_DEPTH));
    busy_o     = (state_q == StLocked);
    grant_o    = busy_o ? owner_q : '0;
    ic_rdy_o   = grant_o & {IN_N{~full}};
    push       = |(data_vld_i & ic_rdy_o);
    tail_xfer  = |(data_vld_i & flit_id_is_tail_i & ic_rdy_o);
    oc_vld_o   = (cnt_q != '0);
    pop        = oc_vld_o && oc_rdy_i;
    oc_data_o  = mem_q[rd_ptr_q];
    fifo_cnt_o = cnt_q;
  end

  // Lock FSM next state: grab a winner in idle, release on tail transfer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          owner_d = IN_N'(1) << win_idx;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (tail_xfer) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (!push && pop) cnt_d = cnt_q - CntW'(1);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset since cnt_q gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
